// File: rtl/spi_host_win_pkg.sv
// Shared types and defaults for the SPI host TX/RX data windows.
// Empty-RX-read policy is selected by SPI_HOST_WIN_RX_STALL_EN in the top.
package spi_host_win_pkg;

  localparam int unsigned TxDepthDef = 4;
  localparam int unsigned RxDepthDef = 4;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  be;
  } tx_entry_t;

  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        valid;
  } win_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        error;
    logic        ready;
  } win_rsp_t;

endpackage

// File: rtl/spi_host_win_fifo.sv
// Parametric FIFO with flush and level; storage is not reset,
// head output is masked to zero while empty.
module spi_host_win_fifo #(
  parameter type         T     = logic [31:0],
  parameter int unsigned Depth = 4,
  localparam int unsigned PW   = $clog2(Depth),
  localparam int unsigned LW   = $clog2(Depth + 1)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          flush_i,
  input  logic          push_i,
  input  T              data_i,
  input  logic          pop_i,
  output T              data_o,
  output logic [LW-1:0] lvl_o
);

  T              mem [Depth];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic [LW-1:0] lvl;
  logic          do_push;
  logic          do_pop;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(Depth - 1)) ? '0 : p + PW'(1);
  endfunction

  assign do_pop  = pop_i & (lvl != '0);
  assign do_push = push_i & ((lvl != LW'(Depth)) | do_pop);

  always_ff @(posedge clk_i) begin
    if (!rst_ni || flush_i) begin
      wptr <= '0;
      rptr <= '0;
      lvl  <= '0;
    end else begin
      if (do_push) wptr <= nxt(wptr);
      if (do_pop)  rptr <= nxt(rptr);
      unique case ({do_push, do_pop})
        2'b10:   lvl <= lvl + LW'(1);
        2'b01:   lvl <= lvl - LW'(1);
        default: lvl <= lvl;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wptr] <= data_i;
  end

  assign data_o = (lvl != '0) ? mem[rptr] : T'('0);
  assign lvl_o  = lvl;

endmodule

// File: rtl/spi_host_data_win.sv
// Regbus TX/RX data windows in front of the SPI shift engine.
// SPI_HOST_WIN_RX_STALL_EN: empty RX reads stall instead of erroring.
module spi_host_data_win
  import spi_host_win_pkg::*;
#(
  parameter type          reg_req_t = win_req_t,
  parameter type          reg_rsp_t = win_rsp_t,
  parameter int unsigned  TxDepth   = TxDepthDef,
  parameter int unsigned  RxDepth   = RxDepthDef,
  localparam int unsigned TxLW      = $clog2(TxDepth + 1),
  localparam int unsigned RxLW      = $clog2(RxDepth + 1)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  reg_req_t        tx_win_i,
  output reg_rsp_t        tx_win_o,
  input  reg_req_t        rx_win_i,
  output reg_rsp_t        rx_win_o,
  output logic [31:0]     tx_data_o,
  output logic [3:0]      tx_be_o,
  output logic            tx_valid_o,
  input  logic            tx_ready_i,
  input  logic [31:0]     rx_data_i,
  input  logic            rx_valid_i,
  output logic            rx_ready_o,
  input  logic            tx_flush_i,
  input  logic            rx_flush_i,
  output logic [TxLW-1:0] tx_lvl_o,
  output logic [RxLW-1:0] rx_lvl_o,
  output logic            rx_underflow_o,
  output logic            rx_wr_err_o,
  output logic            tx_rd_err_o
);

  if ($bits(tx_win_i.wdata) != 32) begin : g_wdata_chk
    $error("regbus wdata must be 32 bit");
  end
  if (TxDepth < 2 || TxDepth > 64) begin : g_tx_depth_chk
    $error("TxDepth out of range 2..64");
  end
  if (RxDepth < 2 || RxDepth > 64) begin : g_rx_depth_chk
    $error("RxDepth out of range 2..64");
  end

  tx_entry_t   tx_in;
  tx_entry_t   tx_head;
  logic        tx_wr;
  logic        tx_rd;
  logic        tx_pop;
  logic        tx_room;
  logic        tx_ack;
  logic        tx_push;
  logic [31:0] rx_head;
  logic        rx_wr;
  logic        rx_rd;
  logic        rx_pop;
  logic        rx_empty_rd;
  logic        rx_push;
  logic        unused_bits;

  assign unused_bits = ^{tx_win_i.addr, rx_win_i.addr,
                         rx_win_i.wdata, rx_win_i.wstrb};

  // TX side: writes stall only when full and no pop this cycle
  assign tx_wr      = rst_ni & tx_win_i.valid & tx_win_i.write;
  assign tx_rd      = rst_ni & tx_win_i.valid & ~tx_win_i.write;
  assign tx_valid_o = tx_lvl_o != '0;
  assign tx_pop     = tx_valid_o & tx_ready_i;
  assign tx_room    = (tx_lvl_o != TxLW'(TxDepth)) | tx_pop;
  assign tx_ack     = tx_wr & (tx_room | tx_flush_i);
  assign tx_push    = tx_ack & (|tx_win_i.wstrb) & ~tx_flush_i;
  assign tx_in      = '{data: tx_win_i.wdata, be: tx_win_i.wstrb};
  assign tx_data_o  = tx_head.data;
  assign tx_be_o    = tx_head.be;
  assign tx_rd_err_o = tx_rd;

  always_comb begin
    tx_win_o       = '0;
    tx_win_o.ready = tx_ack | tx_rd;
    tx_win_o.error = tx_rd;
  end

  spi_host_win_fifo #(
    .T     (tx_entry_t),
    .Depth (TxDepth)
  ) u_tx_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (tx_flush_i),
    .push_i  (tx_push),
    .data_i  (tx_in),
    .pop_i   (tx_pop),
    .data_o  (tx_head),
    .lvl_o   (tx_lvl_o)
  );

  assign rx_wr       = rst_ni & rx_win_i.valid & rx_win_i.write;
  assign rx_rd       = rst_ni & rx_win_i.valid & ~rx_win_i.write;
  assign rx_pop      = rx_rd & (rx_lvl_o != '0);
  assign rx_empty_rd = rx_rd & (rx_lvl_o == '0);
  assign rx_ready_o  = (rx_lvl_o != RxLW'(RxDepth)) | rx_pop;
  assign rx_push     = rx_valid_i & rx_ready_o;
  assign rx_wr_err_o = rx_wr;

  always_comb begin
    rx_win_o       = '0;
    rx_underflow_o = 1'b0;
    unique case (1'b1)
      rx_wr: begin
        rx_win_o.ready = 1'b1;
        rx_win_o.error = 1'b1;
      end
      rx_pop: begin
        rx_win_o.ready = 1'b1;
        rx_win_o.rdata = rx_head;
      end
`ifdef SPI_HOST_WIN_RX_STALL_EN
      rx_empty_rd: rx_win_o.ready = 1'b0;
`else
      rx_empty_rd: begin
        rx_win_o.ready = 1'b1;
        rx_win_o.error = 1'b1;
        rx_underflow_o = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  spi_host_win_fifo #(
    .T     (logic [31:0]),
    .Depth (RxDepth)
  ) u_rx_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (rx_flush_i),
    .push_i  (rx_push),
    .data_i  (rx_data_i),
    .pop_i   (rx_pop),
    .data_o  (rx_head),
    .lvl_o   (rx_lvl_o)
  );

endmodule

// File: doc/spi_host_data_win.md
SPI_HOST_DATA_WIN -- requirements
Module: spi_host_data_win

Interface
REQ-001 Param reg_req_t, logic, regbus request struct; wdata SHALL be 32 bit, checked by an init assertion.
REQ-002 Param reg_rsp_t, logic, regbus response struct.
REQ-003 Param TxDepth, 4, TX FIFO entries; legal range 2..64.
REQ-004 Param RxDepth, 4, RX FIFO entries; legal range 2..64.
REQ-005 Port clk_i  in  1  clock.
REQ-006 Port rst_ni  in  1  reset; synchronous, active-low.
REQ-007 Port tx_win_i / tx_win_o  in/out  struct  TX window regbus request/response.
REQ-008 Port rx_win_i / rx_win_o  in/out  struct  RX window regbus request/response.
REQ-009 Port tx_data_o  out  32  TX FIFO head data; tx_be_o  out  4  TX FIFO head byte enables.
REQ-010 Port tx_valid_o  out  1 / tx_ready_i  in  1  TX handshake to shift engine.
REQ-011 Port rx_data_i  in  32 / rx_valid_i  in  1 / rx_ready_o  out  1  RX handshake from shift engine.
REQ-012 Port tx_flush_i, rx_flush_i  in  1 each  synchronous FIFO clear.
REQ-013 Port tx_lvl_o  out  $clog2(TxDepth+1); rx_lvl_o  out  $clog2(RxDepth+1)  fill levels.
REQ-014 Port rx_underflow_o, rx_wr_err_o, tx_rd_err_o  out  1 each  one-cycle event pulses.

Function
REQ-015 TX write accepted (tx_win_o.ready=1) when valid&write and (level<TxDepth or tx_valid_o&tx_ready_i same cycle); else ready=0 (stall), no push.
REQ-016 Accepted TX write with wstrb!=0 SHALL push {wdata,wstrb}; wstrb==0 SHALL be acked, not pushed.
REQ-017 Pushed entry SHALL appear on tx_data_o/tx_be_o no earlier than the next cycle; no same-cycle bypass.
REQ-018 TX pop SHALL occur on tx_valid_o&tx_ready_i; tx_valid_o = (tx_lvl_o!=0).
REQ-019 TX window read SHALL respond ready=1, error=1, rdata=0, pulse tx_rd_err_o; FIFO unchanged.
REQ-020 rx_ready_o = (rx_lvl_o<RxDepth) or RX pop same cycle; push on rx_valid_i&rx_ready_o.
REQ-021 RX read with level!=0 SHALL respond ready=1, error=0, rdata=head, and pop; response combinational from registered head.
REQ-022 RX read with level==0: behaviour per REQ-031.
REQ-023 RX window write SHALL respond ready=1, error=1, pulse rx_wr_err_o; FIFO unchanged.
REQ-024 Simultaneous push and pop on any FIFO SHALL leave level unchanged; pointers wrap modulo depth (non-power-of-2 depths supported).
REQ-025 Flush SHALL zero level and pointers next cycle; flush wins over same-cycle push/pop; the regbus write is still acked and its data discarded.
REQ-026 Levels SHALL never exceed depth nor go below 0 under any input combination.

Reset
REQ-027 Synchronous reset SHALL zero pointers and levels; tx_valid_o=0, all pulses=0.
REQ-028 Reset during a stalled regbus access SHALL drop it; no push/pop in the reset cycle.
REQ-029 FIFO data storage SHALL NOT be reset; outputs SHALL be masked by level, so stale data is never visible.

Configuration
REQ-030 Macro SPI_HOST_WIN_RX_STALL_EN selects empty-read policy.
REQ-031 Defined: RX read on empty SHALL hold rx_win_o.ready=0 until an entry exists, then complete per REQ-021; never pulse rx_underflow_o. Undefined: immediate ready=1, error=1, rdata=0, rx_underflow_o pulse, no pop.

Structure
REQ-032 Package spi_host_win_pkg SHALL hold tx_entry_t {data[31:0], be[3:0]} and default depth constants.
REQ-033 Sub-module spi_host_win_fifo (parametric type and depth, flush, level output) SHALL be instantiated once for TX, once for RX.

Verification
REQ-034 Write 0xDEADBEEF wstrb=0xF, tx_ready_i=0 -> next cycle tx_valid_o=1, tx_data_o=0xDEADBEEF, tx_be_o=0xF, tx_lvl_o=1.
REQ-035 TxDepth=4, 5 writes, tx_ready_i=0 -> 5th stalls ready=0; raise tx_ready_i -> 5th accepted same cycle, level stays 4.
REQ-036 Push 0x11,0x22 on RX, read twice -> rdata 0x11 then 0x22, error=0, rx_lvl_o 2->1->0.
REQ-037 Empty RX read: macro off -> error=1, rdata=0, rx_underflow_o pulse; macro on -> stall, rx_valid_i with 0x33 -> completes 0x33 next cycle.
REQ-038 tx_lvl_o=3, tx_flush_i with concurrent write -> next cycle tx_lvl_o=0, tx_valid_o=0, write acked.
REQ-039 rst_ni low mid-stream with both FIFOs non-empty -> next cycle levels 0, tx_valid_o=0, rx_ready_o=1.
